fir_requant_decim: RTL

Output stage that sits directly downstream of the transversal FIR. It takes the full-precision 32-bit FIR result, one sample per clock, and discards the start-up transient. It then decimates by DECIM, rounds and saturates the Q15-scaled product back to 16 bits, and buffers the result in a small FIFO with a valid/ready interface towards the consumer.

---
 rtl/fir_requant_decim.sv | 106 ++++++++++
 1 files changed

// File: rtl/fir_requant_decim.sv
// FIR output stage: drops the fill transient, decimates, rounds/saturates Q15 results
// to OUT_W bits and buffers them in a first-word-fall-through FIFO.
module fir_requant_decim #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter int DECIM  = 4,
    parameter int WARMUP = 26,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [IN_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]    fill,
    output logic                      sat_flag,
    output logic                      ovf_flag,
    input  logic                      clear_flags
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int WU_W = $clog2(WARMUP + 2);
    localparam int PH_W = $clog2(DECIM + 1);

    localparam logic signed [IN_W:0] RND  = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = ~MAXV;

    logic [WU_W-1:0]         wu_cnt;
    logic [PH_W-1:0]         phase;
    logic                    s1_valid;
    logic signed [OUT_W-1:0] s1_data;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic signed [OUT_W-1:0] last_data;
    logic signed [OUT_W-1:0] mem [DEPTH];

    logic signed [IN_W:0]    ext, sum, shf;
    logic signed [OUT_W-1:0] q;
    logic                    sat, warm_done, keep, full, pop, do_write;

    always_comb begin
        ext = {in_data[IN_W-1], in_data};
        sum = ext + RND;
        shf = sum >>> SHIFT;
        sat = 1'b0;
        q   = shf[OUT_W-1:0];
        if (shf > MAXV) begin
            sat = 1'b1;
            q   = MAXV[OUT_W-1:0];
        end else if (shf < MINV) begin
            sat = 1'b1;
            q   = MINV[OUT_W-1:0];
        end
    end

    assign warm_done = (wu_cnt == WU_W'(WARMUP));
    assign keep      = in_valid && warm_done && (phase == '0);

    assign fill      = wr_ptr - rd_ptr;
    assign out_valid = (fill != '0);
    assign full      = (fill == PW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign do_write  = s1_valid && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : last_data;

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr[AW-1:0]] <= s1_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wu_cnt    <= '0;
            phase     <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_data <= '0;
            sat_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            if (in_valid) begin
                if (!warm_done)
                    wu_cnt <= wu_cnt + 1'b1;
                else
                    phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
            s1_valid <= keep;
            if (keep)
                s1_data <= q;
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_data <= mem[rd_ptr[AW-1:0]];
            end
            sat_flag <= (sat_flag && !clear_flags) || (keep && sat);
            ovf_flag <= (ovf_flag && !clear_flags) || (s1_valid && full && !pop);
        end
    end
endmodule
